// File: rtl/vx_stream_demux.sv
// rtl/vx_stream_demux.sv - one-to-N valid/ready stream demultiplexer
//
// Purpose:
//   Steers each beat accepted on the input stream to the single output
//   selected by sel_in.
//   BUFFERED=0: combinational passthrough, zero latency.
//   BUFFERED=1: a 2-entry in-order FIFO per output. ready_in depends on
//               registered FIFO state only, so there is no ready_out ->
//               ready_in combinational path.
//   A select index >= NUM_REQS is accepted and dropped, and it raises the
//   sticky sel_err flag.
//
// Ports:
//   clk          rising-edge clock for all state.
//   reset        synchronous active-low reset.
//   valid_in     upstream beat valid.
//   sel_in       destination output index (SELW bits).
//   data_in      payload (DATAW bits).
//   ready_in     upstream beat accepted when valid_in && ready_in.
//   valid_out    per-output valid (NUM_REQS bits).
//   data_out     per-output payload, output i in bits [i*DATAW +: DATAW].
//   ready_out    per-output consumer ready (NUM_REQS bits).
//   sel_err      sticky flag: an out-of-range sel_in was seen with valid_in.
//   perf_stalls  (VX_STREAM_DEMUX_PERF_EN only) saturating count of cycles
//                with valid_in && !ready_in.
//
// Optional feature macro: VX_STREAM_DEMUX_PERF_EN

module vx_stream_demux #(
  parameter  int NUM_REQS = 4,
  parameter  int DATAW    = 32,
  parameter  int BUFFERED = 1,
  localparam int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [SELW-1:0]           sel_in,
  input  logic [DATAW-1:0]          data_in,
  output logic                      ready_in,
  output logic [NUM_REQS-1:0]       valid_out,
  output logic [NUM_REQS*DATAW-1:0] data_out,
  input  logic [NUM_REQS-1:0]       ready_out,
  output logic                      sel_err
`ifdef VX_STREAM_DEMUX_PERF_EN
  ,
  output logic [31:0]               perf_stalls
`endif
);

  // Every SELW-bit index addresses a slot in the padded vectors below,
  // so an out-of-range select never indexes past the end of a vector.
  localparam int NSEL = 1 << SELW;

  logic [SELW-1:0]     w_sel;
  logic                w_sel_ok;
  logic [NUM_REQS-1:0] w_route;
  logic                r_sel_err;

  // With a single output the select input carries no information.
  assign w_sel    = (NUM_REQS == 1) ? '0 : sel_in;
  assign w_sel_ok = (NUM_REQS == 1) ? 1'b1 : (32'(w_sel) < NUM_REQS);

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_route
    assign w_route[g] = valid_in && w_sel_ok && (w_sel == SELW'(g));
  end

  if (BUFFERED == 0) begin : g_pass
    logic [NSEL-1:0] w_ready_ext;

    assign w_ready_ext = NSEL'(ready_out);
    assign valid_out   = w_route;
    // Dropped beats are always accepted.
    assign ready_in    = w_sel_ok ? w_ready_ext[w_sel] : 1'b1;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_data
      assign data_out[g*DATAW +: DATAW] = data_in;
    end
  end else begin : g_buf
    logic [NUM_REQS-1:0] w_full;
    logic [NSEL-1:0]     w_full_ext;

    assign w_full_ext = NSEL'(w_full);
    assign ready_in   = w_sel_ok ? !w_full_ext[w_sel] : 1'b1;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_fifo
      logic [DATAW-1:0] r_mem [2];
      logic [1:0]       r_count;
      logic             r_wr_ptr;
      logic             r_rd_ptr;
      logic             w_push;
      logic             w_pop;

      // A full FIFO refuses the push even when it pops in the same cycle;
      // this keeps ready_in a function of registered state only.
      assign w_full[g] = (r_count == 2'd2);
      assign w_push    = w_route[g] && !w_full[g];
      assign w_pop     = (r_count != 2'd0) && ready_out[g];

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_count  <= 2'd0;
          r_wr_ptr <= 1'b0;
          r_rd_ptr <= 1'b0;
        end else begin
          if (w_push) r_wr_ptr <= ~r_wr_ptr;
          if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
          // Push and pop together leave the count unchanged; at count 1
          // the read pointer moves onto the slot just written.
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
          endcase
        end
      end

      // Payload storage needs no reset; validity is carried by r_count.
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
      end

      assign valid_out[g]               = (r_count != 2'd0);
      assign data_out[g*DATAW +: DATAW] = r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel_err <= 1'b0;
    end else if (valid_in && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

`ifdef VX_STREAM_DEMUX_PERF_EN
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_stalls <= 32'd0;
    end else if (valid_in && !ready_in && (r_perf_stalls != 32'hFFFF_FFFF)) begin
      r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_stream_demux.sv
// tb/tb_vx_stream_demux.sv - self-checking bench for vx_stream_demux

module tb_vx_stream_demux;

  logic clk;
  logic resetn;

  // NUM_REQS=4, BUFFERED=1
  logic        b4_valid;
  logic [1:0]  b4_sel;
  logic [7:0]  b4_data;
  logic        b4_ready_in;
  logic [3:0]  b4_vo;
  logic [31:0] b4_do;
  logic [3:0]  b4_ro;
  logic        b4_err;
  logic [31:0] b4_perf;

  // NUM_REQS=3, BUFFERED=1
  logic        b3_valid;
  logic [1:0]  b3_sel;
  logic [7:0]  b3_data;
  logic        b3_ready_in;
  logic [2:0]  b3_vo;
  logic [23:0] b3_do;
  logic [2:0]  b3_ro;
  logic        b3_err;
  logic [31:0] b3_perf;

  // NUM_REQS=4, BUFFERED=0
  logic        p4_valid;
  logic [1:0]  p4_sel;
  logic [7:0]  p4_data;
  logic        p4_ready_in;
  logic [3:0]  p4_vo;
  logic [31:0] p4_do;
  logic [3:0]  p4_ro;
  logic        p4_err;
  logic [31:0] p4_perf;

  int n_checks;
  int n_errors;

  vx_stream_demux #(.NUM_REQS(4), .DATAW(8), .BUFFERED(1)) u_b4 (
    .clk(clk), .reset(resetn), .valid_in(b4_valid), .sel_in(b4_sel),
    .data_in(b4_data), .ready_in(b4_ready_in), .valid_out(b4_vo),
    .data_out(b4_do), .ready_out(b4_ro), .sel_err(b4_err)
`ifdef VX_STREAM_DEMUX_PERF_EN
    , .perf_stalls(b4_perf)
`endif
  );

  vx_stream_demux #(.NUM_REQS(3), .DATAW(8), .BUFFERED(1)) u_b3 (
    .clk(clk), .reset(resetn), .valid_in(b3_valid), .sel_in(b3_sel),
    .data_in(b3_data), .ready_in(b3_ready_in), .valid_out(b3_vo),
    .data_out(b3_do), .ready_out(b3_ro), .sel_err(b3_err)
`ifdef VX_STREAM_DEMUX_PERF_EN
    , .perf_stalls(b3_perf)
`endif
  );

  vx_stream_demux #(.NUM_REQS(4), .DATAW(8), .BUFFERED(0)) u_p4 (
    .clk(clk), .reset(resetn), .valid_in(p4_valid), .sel_in(p4_sel),
    .data_in(p4_data), .ready_in(p4_ready_in), .valid_out(p4_vo),
    .data_out(p4_do), .ready_out(p4_ro), .sel_err(p4_err)
`ifdef VX_STREAM_DEMUX_PERF_EN
    , .perf_stalls(p4_perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns one cycle later at posedge+1, clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    b4_valid = 1'b0; b3_valid = 1'b0; p4_valid = 1'b0;
    b4_ro = '0; b3_ro = '0; p4_ro = '0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  function automatic logic [7:0] b4_d(input int i);
    return b4_do[i*8 +: 8];
  endfunction

  function automatic logic [7:0] b3_d(input int i);
    return b3_do[i*8 +: 8];
  endfunction

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ro;
    logic [3:0] exp_vo;
    logic       exp_ri;
  } pt_vec_t;

  pt_vec_t pt_tab [6];

  // Queue-per-output reference for the randomized run on u_b3.
  logic [7:0] mq [3][$];
  logic       m_err;

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0;
    b4_valid = 1'b0; b4_sel = '0; b4_data = '0; b4_ro = '0;
    b3_valid = 1'b0; b3_sel = '0; b3_data = '0; b3_ro = '0;
    p4_valid = 1'b0; p4_sel = '0; p4_data = '0; p4_ro = '0;
    b4_perf = '0; b3_perf = '0; p4_perf = '0;
    tick();
    reset_all();

    // Reset state
    #1;
    chk("rst_b4_vo", b4_vo, 0);
    chk("rst_b3_vo", b3_vo, 0);
    chk("rst_b4_err", b4_err, 0);
    chk("rst_b4_ready_in", b4_ready_in, 1);
    tick();

    // Passthrough vectors
    pt_tab[0] = '{1'b1, 2'd1, 8'h11, 4'b0010, 4'b0010, 1'b1};
    pt_tab[1] = '{1'b1, 2'd1, 8'h22, 4'b0000, 4'b0010, 1'b0};
    pt_tab[2] = '{1'b0, 2'd2, 8'h33, 4'b1111, 4'b0000, 1'b1};
    pt_tab[3] = '{1'b1, 2'd3, 8'h44, 4'b0111, 4'b1000, 1'b0};
    pt_tab[4] = '{1'b1, 2'd0, 8'h5A, 4'b0001, 4'b0001, 1'b1};
    pt_tab[5] = '{1'b1, 2'd2, 8'hC3, 4'b1011, 4'b0100, 1'b0};
    for (int t = 0; t < 6; t++) begin
      p4_valid = pt_tab[t].v;
      p4_sel   = pt_tab[t].sel;
      p4_data  = pt_tab[t].data;
      p4_ro    = pt_tab[t].ro;
      #1;
      chk("pt_valid_out", p4_vo, pt_tab[t].exp_vo);
      chk("pt_ready_in", p4_ready_in, pt_tab[t].exp_ri);
      for (int i = 0; i < 4; i++) chk("pt_data_out", p4_do[i*8 +: 8], pt_tab[t].data);
      tick();
    end
    p4_valid = 1'b0;
    chk("pt_sel_err", p4_err, 0);

    // Out-of-range select on the 3-output instance
    b3_ro = 3'b111; b3_valid = 1'b1; b3_sel = 2'd3; b3_data = 8'h55;
    #1;
    chk("oob_ready_in", b3_ready_in, 1);
    chk("oob_vo_now", b3_vo, 0);
    chk("oob_err_before", b3_err, 0);
    tick();
    b3_valid = 1'b0;
    #1;
    chk("oob_vo_next", b3_vo, 0);
    chk("oob_err_set", b3_err, 1);
    tick(); tick();
    chk("oob_err_sticky", b3_err, 1);

    // Routing A0..A3 with all outputs ready
    b4_ro = 4'hF;
    for (int k = 0; k < 6; k++) begin
      b4_valid = (k < 4);
      b4_sel   = 2'(k);
      b4_data  = 8'hA0 + 8'(k);
      #1;
      if (k < 4) chk("route_ready_in", b4_ready_in, 1);
      if (k == 0 || k == 5) begin
        chk("route_vo_idle", b4_vo, 0);
      end else begin
        chk("route_vo", b4_vo, 32'd1 << (k - 1));
        chk("route_data", b4_d(k - 1), 8'hA0 + 8'(k - 1));
      end
      tick();
    end

    // Backpressure on output 2
    b4_ro = 4'b1011; b4_valid = 1'b1; b4_sel = 2'd2;
    b4_data = 8'hB0; #1;
    chk("bp_ready_1", b4_ready_in, 1);
    chk("bp_vo_1", b4_vo, 0);
    tick();
    b4_data = 8'hB1; #1;
    chk("bp_ready_2", b4_ready_in, 1);
    chk("bp_vo_2", b4_vo, 4'b0100);
    chk("bp_head_2", b4_d(2), 8'hB0);
    tick();
    b4_data = 8'hB2; #1;
    chk("bp_ready_3", b4_ready_in, 0);
    tick();
    #1;
    chk("bp_hold_ready", b4_ready_in, 0);
    chk("bp_hold_vo", b4_vo, 4'b0100);
    chk("bp_hold_data", b4_d(2), 8'hB0);
    b4_ro = 4'b1111; #1;
    chk("bp_no_comb_path", b4_ready_in, 0);
    tick();
    #1;
    chk("bp_ready_after_pop", b4_ready_in, 1);
    chk("bp_order_1", b4_d(2), 8'hB1);
    tick();
    b4_valid = 1'b0; #1;
    chk("bp_vo_last", b4_vo, 4'b0100);
    chk("bp_order_2", b4_d(2), 8'hB2);
    tick();
    #1;
    chk("bp_drained", b4_vo, 0);

    // Isolation: output 1 full and stalled, output 3 keeps flowing
    b4_ro = 4'b1101; b4_valid = 1'b1; b4_sel = 2'd1;
    b4_data = 8'hC0; tick();
    b4_data = 8'hC1; tick();
    b4_sel = 2'd3; b4_data = 8'hD0; #1;
    chk("iso_ready_1", b4_ready_in, 1);
    chk("iso_vo_1", b4_vo, 4'b0010);
    tick();
    b4_data = 8'hD1; #1;
    chk("iso_ready_2", b4_ready_in, 1);
    chk("iso_vo_2", b4_vo, 4'b1010);
    chk("iso_d3_a", b4_d(3), 8'hD0);
    chk("iso_d1_a", b4_d(1), 8'hC0);
    tick();
    b4_valid = 1'b0; #1;
    chk("iso_vo_3", b4_vo, 4'b1010);
    chk("iso_d3_b", b4_d(3), 8'hD1);
    chk("iso_d1_b", b4_d(1), 8'hC0);
    tick();
    b4_sel = 2'd1; #1;
    chk("iso_vo_4", b4_vo, 4'b0010);
    chk("iso_d1_c", b4_d(1), 8'hC0);
    chk("iso_full_ready", b4_ready_in, 0);

    // Reset mid-operation with FIFOs at 2,1,0,2
    reset_all();
    b4_valid = 1'b1;
    b4_sel = 2'd0; b4_data = 8'hE0; tick();
    b4_sel = 2'd0; b4_data = 8'hE1; tick();
    b4_sel = 2'd1; b4_data = 8'hE2; tick();
    b4_sel = 2'd3; b4_data = 8'hE3; tick();
    b4_sel = 2'd3; b4_data = 8'hE4; tick();
    b4_sel = 2'd0; b4_data = 8'hE5; #1;
    chk("mid_vo_filled", b4_vo, 4'b1011);
    chk("mid_ready_full", b4_ready_in, 0);
    tick();
    b4_valid = 1'b0;
`ifdef VX_STREAM_DEMUX_PERF_EN
    chk("mid_perf_one", b4_perf, 1);
`endif
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("mid_rst_vo", b4_vo, 0);
    chk("mid_rst_err_b4", b4_err, 0);
    chk("mid_rst_err_b3", b3_err, 0);
`ifdef VX_STREAM_DEMUX_PERF_EN
    chk("mid_rst_perf", b4_perf, 0);
`endif
    tick();

    // Randomized run on u_b3 against the queue model
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic rst_now;
      logic exp_ri;
      rst_now  = ($urandom_range(0, 59) == 0);
      resetn   = !rst_now;
      b3_valid = 1'($urandom);
      b3_sel   = 2'($urandom_range(0, 3));
      b3_data  = 8'($urandom);
      b3_ro    = 3'($urandom);
      #1;
      if (b3_sel >= 2'd3) exp_ri = 1'b1;
      else                exp_ri = (mq[b3_sel].size() < 2);
      chk("rnd_ready_in", b3_ready_in, exp_ri);
      for (int i = 0; i < 3; i++) begin
        chk("rnd_valid_out", b3_vo[i], mq[i].size() != 0);
        if (mq[i].size() != 0) chk("rnd_data_out", b3_d(i), mq[i][0]);
      end
      chk("rnd_sel_err", b3_err, m_err);
      if (rst_now) begin
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_err = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++)
          if (mq[i].size() != 0 && b3_ro[i]) void'(mq[i].pop_front());
        if (b3_valid) begin
          if (b3_sel >= 2'd3) m_err = 1'b1;
          else if (exp_ri)    mq[b3_sel].push_back(b3_data);
        end
      end
      tick();
    end
    resetn = 1'b1;
    b3_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vx_stream_demux.md
VX_STREAM_DEMUX -- requirements
Module: VX_stream_demux

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of output streams, 1..16.
REQ-002 SHALL have parameter DATAW, default 32: payload width in bits, >=1.
REQ-003 SHALL have parameter BUFFERED, default 1: 0 = combinational passthrough, 1 = 2-entry FIFO per output.
REQ-004 SHALL define SELW = max(1, CLOG2(NUM_REQS)).
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 SHALL have port: clk  input  1  clock, all state updates on its rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous active-low reset.
REQ-008 SHALL have port: valid_in  input  1  upstream beat valid.
REQ-009 SHALL have port: sel_in  input  SELW  destination output index.
REQ-010 SHALL have port: data_in  input  DATAW  payload.
REQ-011 SHALL have port: ready_in  output  1  upstream beat accepted when valid_in && ready_in.
REQ-012 SHALL have port: valid_out  output  NUM_REQS  per-output valid.
REQ-013 SHALL have port: data_out  output  NUM_REQS x DATAW  per-output payload.
REQ-014 SHALL have port: ready_out  input  NUM_REQS  per-output consumer ready.
REQ-015 SHALL have port: sel_err  output  1  sticky flag, out-of-range sel_in seen.

Function
REQ-016 SHALL route each accepted beat only to output sel_in; no other output observes it.
REQ-017 SHALL, with BUFFERED=0, drive valid_out[i] = valid_in && (sel_in==i), data_out[i] = data_in for every i, ready_in = ready_out[sel_in]; latency 0.
REQ-018 SHALL, with BUFFERED=1, hold a 2-entry FIFO per output with a 2-bit count 0..2, in-order.
REQ-019 SHALL, with BUFFERED=1, drive ready_in = (count[sel_in] != 2), registered-state only; no combinational path from ready_out to ready_in.
REQ-020 SHALL, with BUFFERED=1, drive valid_out[i] = (count[i] != 0) and data_out[i] = head entry of FIFO i; latency 1 cycle from acceptance.
REQ-021 SHALL pop FIFO i on valid_out[i] && ready_out[i].
REQ-022 SHALL, on simultaneous push and pop of the same FIFO at count 1, leave count at 1 with the new beat as head.
REQ-023 SHALL refuse a push at count 2 even if a pop happens in the same cycle.
REQ-024 SHALL hold valid_out[i] and data_out[i] stable while valid_out[i] && !ready_out[i].
REQ-025 SHALL let independent outputs drain concurrently; a stall on one output never blocks pops on another.
REQ-026 SHALL, when sel_in >= NUM_REQS (non-power-of-two NUM_REQS only), assert ready_in, discard the beat, and set sel_err on the next edge if valid_in.
REQ-027 SHALL, when NUM_REQS==1, ignore sel_in and tie sel_err to 0.

Reset
REQ-028 SHALL, while reset==0 at a clock edge, clear all FIFO counts and pointers to 0 and sel_err to 0.
REQ-029 SHALL drive valid_out = 0 in the cycle after reset is sampled low; data_out is don't-care.
REQ-030 SHALL discard in-flight FIFO contents on reset mid-operation, without emitting partial beats.

Configuration
REQ-031 SHALL compile in the macro VX_STREAM_DEMUX_PERF_EN to add output perf_stalls (32-bit): it increments once per cycle with valid_in && !ready_in, saturates at 0xFFFFFFFF, and resets to 0.
REQ-032 SHALL omit the perf_stalls port and counter when VX_STREAM_DEMUX_PERF_EN is undefined; all other behaviour is identical.

Verification
REQ-033 SHALL cover routing: NUM_REQS=4, BUFFERED=1, beats 0xA0..0xA3 with sel_in 0..3, all ready -> each appears once on its own output one cycle after acceptance.
REQ-034 SHALL cover backpressure: ready_out[2]=0, three beats to sel_in=2 -> first two accepted, ready_in=0 on the third, beat held; after ready_out[2]=1, order is preserved.
REQ-035 SHALL cover isolation: output 1 full and stalled; beats to sel_in=3 -> accepted and delivered; output 1 data unchanged.
REQ-036 SHALL cover out-of-range select: NUM_REQS=3, sel_in=3, data 0x55 -> ready_in=1, no valid_out, sel_err=1 next cycle and remains 1 until reset.
REQ-037 SHALL cover reset mid-operation: FIFOs holding 2,1,0,2 entries and reset low for one cycle -> next cycle valid_out=0000, sel_err=0, perf_stalls=0 (if enabled).
REQ-038 SHALL cover passthrough: BUFFERED=0, sel_in=1, ready_out=0010 -> valid_out=0010 in the same cycle, ready_in=1; with ready_out=0000 -> ready_in=0.
